// File: rtl/hbram_pkg.sv
// Shared constants and FSM state type for the HyperRAM write DMA.
package hbram_pkg;

   localparam logic [2:0]  SIZE_16B       = 3'b100;
   localparam logic [1:0]  BURST_INCR     = 2'b01;
   localparam int unsigned BYTES_PER_BEAT = 16;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ADDR,
      DATA,
      RESP,
      DONE
   } state_e;

endpackage

// File: rtl/hbram_sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the head entry.
module hbram_sync_fifo #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 64
) (
   input  logic                     io_axi_clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem[rd_ptr_q];

   // A push while full is accepted only when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_ff @(posedge io_axi_clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge io_axi_clk) begin
      if (do_push) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/hbram_wr_dma.sv
// Write DMA: buffers a 128-bit stream and writes it to the HyperRAM controller
// as single-outstanding INCR bursts, pulsing done when the job is complete.
module hbram_wr_dma
   import hbram_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned BURST_LEN  = 16,
   parameter int unsigned FIFO_DEPTH = 64,
   parameter logic [7:0]  AXI_ID     = 8'h00
) (
   input  logic              io_axi_clk,
   input  logic              rst,
   input  logic              cfg_start,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [23:0]       cfg_total_beats,
   output logic              busy,
   output logic              done,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ADDR_W-1:0] io_arw_payload_addr,
   output logic [7:0]        io_arw_payload_id,
   output logic [7:0]        io_arw_payload_len,
   output logic [2:0]        io_arw_payload_size,
   output logic [1:0]        io_arw_payload_burst,
   output logic [1:0]        io_arw_payload_lock,
   output logic              io_arw_payload_write,
   output logic              io_arw_valid,
   input  logic              io_arw_ready,
   output logic [7:0]        io_w_payload_id,
   output logic [DATA_W-1:0] io_w_payload_data,
   output logic [15:0]       io_w_payload_strb,
   output logic              io_w_payload_last,
   output logic              io_w_valid,
   input  logic              io_w_ready,
   input  logic              io_b_valid,
   input  logic [7:0]        io_b_payload_id,
   output logic              io_b_ready
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [23:0]         remaining_q, remaining_d;
   logic [23:0]         total_q, total_d;
   logic [23:0]         accepted_q, accepted_d;
   logic [7:0]          beat_cnt_q, beat_cnt_d;
   logic                zero_done_q, zero_done_d;

   logic                fifo_full, fifo_empty;
   logic [CW-1:0]       fifo_count;
   logic [DATA_W-1:0]   fifo_head;
   logic [8:0]          burst_beats;
   logic                s_fire, w_fire, is_last;
   logic                unused_b_id;

   assign unused_b_id = ^{io_b_payload_id, fifo_empty};

   hbram_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .io_axi_clk (io_axi_clk),
      .rst        (rst),
      .push       (s_fire),
      .wr_data    (s_data),
      .pop        (w_fire),
      .rd_data    (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   // remaining only changes in RESP, so this stays stable across ADDR and DATA.
   assign burst_beats = (remaining_q >= 24'(BURST_LEN)) ? 9'(BURST_LEN) : remaining_q[8:0];
   assign is_last     = ({1'b0, beat_cnt_q} == (burst_beats - 9'd1));

   assign busy    = (state_q != IDLE);
   assign s_ready = busy && !fifo_full && (accepted_q < total_q);
   assign s_fire  = s_valid && s_ready;
   assign w_fire  = io_w_valid && io_w_ready;

   assign io_arw_payload_id    = AXI_ID;
   assign io_arw_payload_size  = SIZE_16B;
   assign io_arw_payload_burst = BURST_INCR;
   assign io_arw_payload_lock  = 2'b00;
   assign io_arw_payload_write = 1'b1;
   assign io_w_payload_id      = AXI_ID;
   assign io_w_payload_strb    = 16'hFFFF;

   always_comb begin
      io_arw_valid        = (state_q == ADDR);
      io_arw_payload_addr = io_arw_valid ? cur_addr_q : '0;
      io_arw_payload_len  = io_arw_valid ? 8'(burst_beats - 9'd1) : 8'd0;
      io_w_valid          = (state_q == DATA);
      io_w_payload_data   = io_w_valid ? fifo_head : '0;
      io_w_payload_last   = io_w_valid && is_last;
      io_b_ready          = (state_q == RESP);
      done                = (state_q == DONE) || zero_done_q;
   end

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      total_d     = total_q;
      accepted_d  = accepted_q;
      beat_cnt_d  = beat_cnt_q;
      zero_done_d = 1'b0;

      if (s_fire) accepted_d = accepted_q + 24'd1;

      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               if (cfg_total_beats == 24'd0) begin
                  zero_done_d = 1'b1;
               end else begin
                  state_d     = WAIT;
                  cur_addr_d  = cfg_base_addr;
                  remaining_d = cfg_total_beats;
                  total_d     = cfg_total_beats;
                  accepted_d  = 24'd0;
               end
            end
         end
         WAIT: begin
            if (32'(fifo_count) >= 32'(burst_beats)) state_d = ADDR;
         end
         ADDR: begin
            if (io_arw_ready) begin
               state_d    = DATA;
               beat_cnt_d = 8'd0;
            end
         end
         DATA: begin
            if (w_fire) begin
               if (is_last) begin
                  state_d    = RESP;
                  beat_cnt_d = 8'd0;
               end else begin
                  beat_cnt_d = beat_cnt_q + 8'd1;
               end
            end
         end
         RESP: begin
            if (io_b_valid) begin
               cur_addr_d  = cur_addr_q + ADDR_W'(burst_beats) * ADDR_W'(BYTES_PER_BEAT);
               remaining_d = remaining_q - 24'(burst_beats);
               state_d     = (remaining_q == 24'(burst_beats)) ? DONE : WAIT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge io_axi_clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         total_q     <= '0;
         accepted_q  <= '0;
         beat_cnt_q  <= '0;
         zero_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         total_q     <= total_d;
         accepted_q  <= accepted_d;
         beat_cnt_q  <= beat_cnt_d;
         zero_done_q <= zero_done_d;
      end
   end

endmodule

// File: tb/tb_hbram_wr_dma.sv
// Randomized bench for hbram_wr_dma with a transaction-level reference model.
module tb_hbram_wr_dma;

   logic         io_axi_clk = 1'b0;
   logic         rst = 1'b0;
   logic         cfg_start = 1'b0;
   logic [31:0]  cfg_base_addr = '0;
   logic [23:0]  cfg_total_beats = '0;
   logic         busy, done;
   logic [127:0] s_data = '0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [31:0]  io_arw_payload_addr;
   logic [7:0]   io_arw_payload_id, io_arw_payload_len;
   logic [2:0]   io_arw_payload_size;
   logic [1:0]   io_arw_payload_burst, io_arw_payload_lock;
   logic         io_arw_payload_write, io_arw_valid;
   logic         io_arw_ready = 1'b0;
   logic [7:0]   io_w_payload_id;
   logic [127:0] io_w_payload_data;
   logic [15:0]  io_w_payload_strb;
   logic         io_w_payload_last, io_w_valid;
   logic         io_w_ready = 1'b0;
   logic         io_b_valid = 1'b0;
   logic [7:0]   io_b_payload_id = 8'h00;
   logic         io_b_ready;

   hbram_wr_dma u_dut (
      .io_axi_clk           (io_axi_clk),
      .rst                  (rst),
      .cfg_start            (cfg_start),
      .cfg_base_addr        (cfg_base_addr),
      .cfg_total_beats      (cfg_total_beats),
      .busy                 (busy),
      .done                 (done),
      .s_data               (s_data),
      .s_valid              (s_valid),
      .s_ready              (s_ready),
      .io_arw_payload_addr  (io_arw_payload_addr),
      .io_arw_payload_id    (io_arw_payload_id),
      .io_arw_payload_len   (io_arw_payload_len),
      .io_arw_payload_size  (io_arw_payload_size),
      .io_arw_payload_burst (io_arw_payload_burst),
      .io_arw_payload_lock  (io_arw_payload_lock),
      .io_arw_payload_write (io_arw_payload_write),
      .io_arw_valid         (io_arw_valid),
      .io_arw_ready         (io_arw_ready),
      .io_w_payload_id      (io_w_payload_id),
      .io_w_payload_data    (io_w_payload_data),
      .io_w_payload_strb    (io_w_payload_strb),
      .io_w_payload_last    (io_w_payload_last),
      .io_w_valid           (io_w_valid),
      .io_w_ready           (io_w_ready),
      .io_b_valid           (io_b_valid),
      .io_b_payload_id      (io_b_payload_id),
      .io_b_ready           (io_b_ready)
   );

   always #5 io_axi_clk = ~io_axi_clk;

   int tests = 0;
   int fails = 0;

   // Reference model: job bookkeeping, buffered beats and the burst in flight.
   bit           m_busy, m_done_due, m_zero_due, m_in_burst, m_wait_b;
   int unsigned  m_total, m_acc, m_rem, m_beats_left;
   logic [31:0]  m_addr;
   logic [127:0] m_fifo[$];

   logic [31:0]  arw_addr_log[$];
   int unsigned  arw_len_log[$];
   int           last_cnt = 0, done_seen = 0, arw_valid_cycles = 0, arw_stall = 0;
   bit           prev_stall = 1'b0;
   logic [39:0]  prev_arw;

   // Stimulus knobs
   int unsigned sv_pct = 100, wr_mode = 0, arw_delay = 0, b_pct = 100;
   bit          arw_en = 1'b1;
   int unsigned arw_cnt = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(negedge io_axi_clk) begin
      int unsigned  bb;
      bit           was_done, was_zero;
      logic [127:0] dummy;
      bb = (m_rem > 16) ? 16 : m_rem;
      check("const_fields",
            {io_arw_payload_id, io_arw_payload_size, io_arw_payload_burst, io_arw_payload_lock,
             io_arw_payload_write, io_w_payload_id, io_w_payload_strb},
            {8'h00, 3'b100, 2'b01, 2'b00, 1'b1, 8'h00, 16'hFFFF});
      if (rst) begin
         check("rst_ctrl", {busy, done, s_ready, io_arw_valid, io_w_valid, io_w_payload_last,
                            io_b_ready}, 7'd0);
         check("rst_payload", {io_arw_payload_addr, io_arw_payload_len}, 40'd0);
         check("rst_wdata", io_w_payload_data, 128'd0);
         m_busy = 0; m_done_due = 0; m_zero_due = 0; m_in_burst = 0; m_wait_b = 0;
         m_total = 0; m_acc = 0; m_rem = 0; m_beats_left = 0; m_addr = '0;
         m_fifo.delete();
         prev_stall = 0;
      end else begin
         check("busy", busy, m_busy);
         check("done", done, m_done_due || m_zero_due);
         check("s_ready", s_ready, m_busy && (m_acc < m_total) && (m_fifo.size() < 64));
         check("b_ready", io_b_ready, m_wait_b);
         check("w_valid", io_w_valid, m_in_burst);
         if (io_w_valid && m_in_burst) begin
            if (m_fifo.size() == 0) check("w_data_buffered", 0, 1);
            else check("w_data", io_w_payload_data, m_fifo[0]);
            check("w_last", io_w_payload_last, m_beats_left == 1);
         end
         if (io_arw_valid) begin
            arw_valid_cycles++;
            check("arw_legal", m_busy && !m_in_burst && !m_wait_b && (m_rem > 0) &&
                               (m_fifo.size() >= bb), 1);
            check("arw_addr", io_arw_payload_addr, m_addr);
            check("arw_len", io_arw_payload_len, bb - 1);
            if (prev_stall) check("arw_stable", {io_arw_payload_addr, io_arw_payload_len},
                                  prev_arw);
         end
         prev_stall = io_arw_valid && !io_arw_ready;
         prev_arw   = {io_arw_payload_addr, io_arw_payload_len};
         if (prev_stall) arw_stall++;
         if (done) done_seen++;

         was_done = m_done_due;
         was_zero = m_zero_due;
         if (s_valid && s_ready) begin
            m_fifo.push_back(s_data);
            m_acc++;
         end
         if (io_b_valid && m_wait_b) begin
            m_wait_b = 0;
            m_addr   = m_addr + 32'(bb * 16);
            m_rem    = m_rem - bb;
            if (m_rem == 0) m_done_due = 1;
         end
         if (io_w_valid && io_w_ready && m_in_burst) begin
            if (m_fifo.size() > 0) dummy = m_fifo.pop_front();
            if (io_w_payload_last) last_cnt++;
            m_beats_left--;
            if (m_beats_left == 0) begin
               m_in_burst = 0;
               m_wait_b   = 1;
            end
         end
         if (io_arw_valid && io_arw_ready) begin
            m_in_burst   = 1;
            m_beats_left = bb;
            arw_addr_log.push_back(io_arw_payload_addr);
            arw_len_log.push_back(32'(io_arw_payload_len));
         end
         if (was_zero) m_zero_due = 0;
         if (cfg_start && !m_busy) begin
            if (cfg_total_beats == 0) begin
               m_zero_due = 1;
            end else begin
               m_busy  = 1;
               m_total = cfg_total_beats;
               m_rem   = cfg_total_beats;
               m_acc   = 0;
               m_addr  = cfg_base_addr;
            end
         end
         if (was_done) begin
            m_done_due = 0;
            m_busy     = 0;
         end
      end
   end

   // Environment drivers: stream source, arw delay, w_ready pattern, B responder.
   initial begin
      forever begin
         @(posedge io_axi_clk);
         #1;
         s_valid = ($urandom_range(0, 99) < sv_pct);
         s_data  = {$urandom, $urandom, $urandom, $urandom};
         if (io_arw_valid) arw_cnt++;
         else arw_cnt = 0;
         io_arw_ready = arw_en && (arw_cnt >= arw_delay);
         case (wr_mode)
            0:       io_w_ready = 1'b1;
            1:       io_w_ready = ~io_w_ready;
            default: io_w_ready = $urandom_range(0, 1) == 1;
         endcase
         io_b_valid      = ($urandom_range(0, 99) < b_pct);
         io_b_payload_id = 8'($urandom);
      end
   end

   task automatic start_job(input logic [31:0] base, input int unsigned total);
      @(posedge io_axi_clk);
      #1;
      cfg_start       = 1'b1;
      cfg_base_addr   = base;
      cfg_total_beats = 24'(total);
      @(posedge io_axi_clk);
      #1;
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int n = 0;
      while (done_seen == d0 && n < 6000) begin
         @(posedge io_axi_clk);
         n++;
      end
      check(name, done_seen != d0, 1);
   endtask

   task automatic run_job(input logic [31:0] base, input int unsigned total, input string name);
      int d0 = done_seen;
      start_job(base, total);
      wait_done(d0, name);
      repeat (2) @(posedge io_axi_clk);
   endtask

   task automatic fast_env();
      sv_pct = 100; wr_mode = 0; arw_delay = 0; b_pct = 100; arw_en = 1'b1;
   endtask

   task automatic clear_logs();
      arw_addr_log.delete();
      arw_len_log.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, l0, a0, s0, n;
      #1 rst = 1'b1;
      repeat (3) @(posedge io_axi_clk);
      #1 rst = 1'b0;
      fast_env();

      // Aligned 32-beat job
      clear_logs(); l0 = last_cnt; d0 = done_seen;
      run_job(32'h0000_1000, 32, "job_aligned");
      check("aligned_arw_cnt", arw_addr_log.size(), 2);
      check("aligned_addr0", arw_addr_log[0], 32'h0000_1000);
      check("aligned_len0", arw_len_log[0], 15);
      check("aligned_addr1", arw_addr_log[1], 32'h0000_1100);
      check("aligned_len1", arw_len_log[1], 15);
      check("aligned_last_cnt", last_cnt - l0, 2);
      check("aligned_done_cnt", done_seen - d0, 1);

      // Tail burst
      clear_logs(); l0 = last_cnt;
      run_job(32'h0000_2000, 20, "job_tail");
      check("tail_arw_cnt", arw_addr_log.size(), 2);
      check("tail_len0", arw_len_log[0], 15);
      check("tail_addr1", arw_addr_log[1], 32'h0000_2100);
      check("tail_len1", arw_len_log[1], 3);
      check("tail_last_cnt", last_cnt - l0, 2);

      // Backpressure: arw held off five cycles, w_ready toggling
      clear_logs(); l0 = last_cnt; s0 = arw_stall;
      arw_delay = 6; wr_mode = 1; sv_pct = 70; b_pct = 40;
      run_job(32'h0000_A000, 16, "job_backpressure");
      check("bp_arw_stall", arw_stall - s0, 5);
      check("bp_len0", arw_len_log[0], 15);
      check("bp_last_cnt", last_cnt - l0, 1);
      fast_env();

      // Zero-length job
      a0 = arw_valid_cycles; d0 = done_seen;
      run_job(32'h0000_3000, 0, "job_zero");
      check("zero_no_arw", arw_valid_cycles - a0, 0);
      check("zero_done_cnt", done_seen - d0, 1);

      // Start while busy is ignored
      clear_logs(); d0 = done_seen;
      start_job(32'h0000_4000, 48);
      repeat (10) @(posedge io_axi_clk);
      start_job(32'h0000_9000, 5);
      wait_done(d0, "job_ignored_start");
      repeat (2) @(posedge io_axi_clk);
      check("ign_arw_cnt", arw_addr_log.size(), 3);
      check("ign_addr2", arw_addr_log[2], 32'h0000_4200);
      check("ign_done_cnt", done_seen - d0, 1);

      // FIFO fills while arw is stalled, then drains
      clear_logs(); d0 = done_seen;
      arw_en = 1'b0;
      start_job(32'h0000_5000, 100);
      repeat (90) @(posedge io_axi_clk);
      #2;
      check("full_s_ready", s_ready, 0);
      check("full_model_count", m_fifo.size(), 64);
      check("full_accepted", m_acc, 64);
      arw_en = 1'b1;
      wait_done(d0, "job_fifo_full");
      repeat (2) @(posedge io_axi_clk);
      check("full_arw_cnt", arw_addr_log.size(), 7);
      check("full_addr6", arw_addr_log[6], 32'h0000_5600);
      check("full_len6", arw_len_log[6], 3);

      // Address wraps modulo 2^32
      clear_logs();
      run_job(32'hFFFF_FFC0, 20, "job_wrap");
      check("wrap_addr1", arw_addr_log[1], 32'h0000_00C0);
      check("wrap_len1", arw_len_log[1], 3);

      // Randomized jobs under random flow control
      for (int j = 0; j < 10; j++) begin
         sv_pct    = $urandom_range(30, 100);
         wr_mode   = $urandom_range(0, 2);
         arw_delay = $urandom_range(0, 4);
         b_pct     = $urandom_range(20, 100);
         run_job($urandom & 32'hFFFF_FFF0, $urandom_range(0, 70), "job_random");
      end
      fast_env();

      // Reset while beat 7 of the first burst is on the bus
      start_job(32'h0000_7000, 32);
      n = 0;
      while (!(m_in_burst && m_beats_left == 10) && n < 500) begin
         @(posedge io_axi_clk);
         n++;
      end
      check("rst_mid_reached", n < 500, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_outputs", {busy, done, s_ready, io_arw_valid, io_w_valid, io_b_ready}, 6'd0);
      repeat (2) @(posedge io_axi_clk);
      #1 rst = 1'b0;
      clear_logs();
      run_job(32'h0000_8000, 24, "job_after_reset");
      check("post_rst_arw_cnt", arw_addr_log.size(), 2);
      check("post_rst_addr0", arw_addr_log[0], 32'h0000_8000);
      check("post_rst_len1", arw_len_log[1], 7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hbram_wr_dma.md
Name: hbram_wr_dma

Overview:
- Write-side DMA master that sits directly upstream of the HyperRAM controller on the io_axi_clk domain.
- Buffers a 128-bit data stream, for example from a camera or video pipeline, in an internal FIFO.
- Issues INCR write bursts on the controller's combined arw channel, drives the W channel, and consumes B responses.
- Signals completion of a configured transfer of N beats starting at a base address.

Parameters:
- ADDR_W, 32, address width of arw payload.
- DATA_W, 128, data beat width; fixed at 128 in this design.
- BURST_LEN, 16, maximum beats per burst (1..256).
- FIFO_DEPTH, 64, entries of input FIFO; power of two, >= BURST_LEN.
- AXI_ID, 8'h00, constant ID driven on arw and w.

Ports:
- io_axi_clk  in  1  single clock
- rst  in  1  asynchronous active-high reset
- cfg_start  in  1  one-cycle pulse; latches cfg_base_addr and cfg_total_beats when idle
- cfg_base_addr  in  32  byte address of first beat; must be 16-byte aligned
- cfg_total_beats  in  24  beats in the job
- busy  out  1  job in progress
- done  out  1  one-cycle pulse on job completion
- s_data  in  128  input stream data
- s_valid  in  1  input stream valid
- s_ready  out  1  input stream ready
- io_arw_payload_addr  out  32  burst address
- io_arw_payload_id  out  8  AXI_ID
- io_arw_payload_len  out  8  beats-1
- io_arw_payload_size  out  3  constant 3'b100
- io_arw_payload_burst  out  2  constant 2'b01 (INCR)
- io_arw_payload_lock  out  2  constant 0
- io_arw_payload_write  out  1  constant 1
- io_arw_valid  out  1  address valid
- io_arw_ready  in  1  address ready
- io_w_payload_id  out  8  AXI_ID
- io_w_payload_data  out  128  FIFO head
- io_w_payload_strb  out  16  constant 16'hFFFF
- io_w_payload_last  out  1  last beat of burst
- io_w_valid  out  1  write data valid
- io_w_ready  in  1  write data ready
- io_b_valid  in  1  response valid
- io_b_payload_id  in  8  response ID; ignored
- io_b_ready  out  1  response ready

Behaviour:
Reset values:
- All outputs 0 except the constant payload fields.
- FSM in IDLE; FIFO empty; counters cleared.
- An asserted rst mid-burst aborts immediately. No completion of the outstanding AXI transaction is attempted; system reset covers the controller.

Job start and input stream:
- cfg_start while busy=1 is ignored.
- On start with total=0: done pulses on the next cycle and no arw is issued.
- On start with total>0: busy=1 from the next cycle until the cycle done pulses.
- s_ready = busy && FIFO not full && accepted_cnt < total.
- Beat accepted when s_valid && s_ready. FIFO write happens in the same cycle.

FSM states and transitions:
- IDLE -> WAIT on start with total>0.
- WAIT: compute burst_beats = min(BURST_LEN, remaining). Go to ADDR when fifo_count >= burst_beats.
- ADDR: io_arw_valid=1, payload held stable until io_arw_ready. Address = cur_addr, len = burst_beats-1. On handshake go to DATA.
- DATA:
  - io_w_valid = 1. It never drops mid-burst because the burst beats are already buffered.
  - FIFO pops on io_w_valid && io_w_ready.
  - io_w_payload_last = 1 when beat_cnt == burst_beats-1.
  - After the last beat handshake go to RESP.
- RESP: io_b_ready=1. On io_b_valid:
  - cur_addr += burst_beats*16;
  - remaining -= burst_beats;
  - if remaining==0 go to DONE, else go to WAIT.
- DONE: done=1 for one cycle, busy=0 from the next cycle, then IDLE.

Concurrency and arithmetic:
- Only one burst is outstanding at a time. Input accept continues concurrently in all non-IDLE states.
- FIFO push and pop in the same cycle keep count unchanged, including when the FIFO is full.
- Address arithmetic is modulo 2^32; there is no 4 KB boundary splitting.

Decomposition:
- Shared package hbram_pkg holds:
  - constants for AXI SIZE_16B = 3'b100 and BURST_INCR = 2'b01;
  - the FSM state enum {IDLE, WAIT, ADDR, DATA, RESP, DONE};
  - BYTES_PER_BEAT = 16.
- Sub-module hbram_sync_fifo: show-ahead synchronous FIFO, parameters WIDTH and DEPTH, ports push/pop/full/empty/count, asynchronous reset.

Test Plan:
- Aligned job: base=0x1000, total=32, stream continuous, all readies 1 -> two arw: addr 0x1000 len 15, then addr 0x1100 len 15. Data order matches input, last on beats 16 and 32, done once after the second B.
- Tail burst: total=20 -> bursts len 15 at base, then len 3 at base+0x100. io_w_payload_last on the 4th beat of the second burst.
- Backpressure: io_arw_ready delayed 5 cycles, io_w_ready toggling 1/0 -> arw payload stable while waiting, no data loss or duplication, io_w_valid stays high through the burst, last still on beat 16.
- Zero/ignored start: total=0 -> done one cycle after start, io_arw_valid never asserted. A second cfg_start during a busy job is ignored with no parameter change.
- FIFO full: s_valid constant, io_arw_ready=0 -> s_ready drops when FIFO count reaches 64. Resumes after bursts drain. Simultaneous push and pop at full is lossless.
- Reset mid-burst: assert rst during DATA beat 7 -> all outputs 0 immediately, FIFO empty. A new job after reset completes normally.
